// File: rtl/note_pkg.sv
// note_pkg: shared state encoding, note width and lane bit positions for the note scheduler
package note_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_BEAT, FETCH, LATCH, ISSUE, DONE} state_t;
  localparam int NOTE_W = 5;
  localparam int G = 4;
  localparam int R = 3;
  localparam int Y = 2;
  localparam int B = 1;
  localparam int O = 0;
endpackage

// File: rtl/note_lane_decode.sv
// note_lane_decode: maps a 3-bit random value to a one-hot lane word (0..4 -> g..o, 5..7 -> rest)
module note_lane_decode
  import note_pkg::*;
(
  input  logic [2:0]        sel,
  output logic [NOTE_W-1:0] lanes
);
  // one lane per value, values above 4 give an empty note
  always_comb begin
    lanes = '0;
    lanes[G] = sel == 3'd0;
    lanes[R] = sel == 3'd1;
    lanes[Y] = sel == 3'd2;
    lanes[B] = sel == 3'd3;
    lanes[O] = sel == 3'd4;
  end
endmodule

// File: rtl/note_scheduler.sv
// note_scheduler: beat-paced note issue from a chart ROM; NOTE_SCHED_RANDOM_EN adds a random note source
module note_scheduler
  import note_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] END_ADDR = 8'hFF
) (
  input  logic              Clk,
  input  logic              RESET,
  input  logic              beat_tick,
  input  logic              start,
  input  logic              pause,
  input  logic              mode,
  input  logic [NOTE_W-1:0] chart_data,
  input  logic [2:0]        rand_bits,
  output logic [ADDR_W-1:0] chart_addr,
  output logic [NOTE_W-1:0] lane_strobe,
  output logic              busy,
  output logic              song_done,
  output logic [15:0]       note_count,
  output logic              overrun
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] strobe_q, strobe_d;
  logic [15:0]       count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mode_q, mode_d;
  logic [NOTE_W-1:0] word;
  logic              rnd;
`ifdef NOTE_SCHED_RANDOM_EN
  logic [NOTE_W-1:0] rand_word;
  note_lane_decode u_decode (.sel(rand_bits), .lanes(rand_word));
  assign word = mode_q ? rand_word : chart_data;
  assign rnd  = mode_q;
`else
  logic unused_rand;
  assign unused_rand = ^{mode_q, rand_bits};
  assign word = chart_data;
  assign rnd  = 1'b0;
`endif
  // next-state and next-output logic; the strobe register doubles as the captured note word
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    strobe_d  = '0;
    count_d   = count_q;
    overrun_d = overrun_q | (beat_tick & (state_q inside {FETCH, LATCH, ISSUE}));
    mode_d    = mode_q;
    case (state_q)
      IDLE: if (start) begin
        state_d   = WAIT_BEAT;
        addr_d    = '0;
        count_d   = '0;
        overrun_d = 1'b0;
        mode_d    = mode;
      end
      WAIT_BEAT: state_d = (beat_tick && !pause) ? FETCH : WAIT_BEAT;
      FETCH:     state_d = LATCH;
      LATCH: begin
        state_d  = ISSUE;
        strobe_d = word;
      end
      ISSUE: begin
        count_d = (strobe_q != '0 && count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
        state_d = (!rnd && addr_q == END_ADDR) ? DONE : WAIT_BEAT;
        addr_d  = (rnd || addr_q == END_ADDR) ? addr_q : addr_q + ADDR_W'(1);
      end
      DONE:    state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = !(state_d inside {IDLE, DONE});
    done_d = state_d == DONE;
  end
  // state and registered outputs, reset overrides everything
  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      strobe_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      strobe_q  <= strobe_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
    end
  end
  assign chart_addr  = addr_q;
  assign lane_strobe = strobe_q;
  assign busy        = busy_q;
  assign song_done   = done_q;
  assign note_count  = count_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_note_scheduler.sv
// tb_note_scheduler: directed checks of beat pacing, song end, overrun, pause and reset
module tb_note_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       beat_tick = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] chart_data = '0;
  logic [2:0] rand_bits = '0;
  logic [7:0] chart_addr;
  logic [4:0] lane_strobe;
  logic       busy, song_done, overrun;
  logic [15:0] note_count;
  logic [4:0] rom [0:255];
  logic [4:0] s;
  int n_cmp = 0;
  int n_err = 0;

  note_scheduler #(.ADDR_W(8), .END_ADDR(8'd2)) dut (
    .Clk(clk), .RESET(rst), .beat_tick(beat_tick), .start(start), .pause(pause),
    .mode(mode), .chart_data(chart_data), .rand_bits(rand_bits), .chart_addr(chart_addr),
    .lane_strobe(lane_strobe), .busy(busy), .song_done(song_done),
    .note_count(note_count), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) chart_data <= rom[chart_addr];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; beat_tick = 1'b0; start = 1'b0; pause = 1'b0; mode = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic start_song();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic tick();
    beat_tick = 1'b1;
    step(1);
    beat_tick = 1'b0;
  endtask

  task automatic tick_and_get(output logic [4:0] st);
    tick();
    step(2);
    st = lane_strobe;
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (chart_addr !== 8'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", chart_addr); end
    n_cmp++; if (lane_strobe !== 5'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 00000", lane_strobe); end
    n_cmp++; if (busy !== 1'b0 || song_done !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, song_done); end
    n_cmp++; if (note_count !== 16'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_count: got cnt=%0d ovr=%b want 0 0", note_count, overrun); end
  endtask

  task automatic test_chart();
    do_reset();
    start_song();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL chart_busy: got %b want 1", busy); end
    tick();
    step(1);
    n_cmp++; if (lane_strobe !== 5'b0) begin n_err++; $display("FAIL chart_early: got %b want 00000", lane_strobe); end
    step(1);
    n_cmp++; if (lane_strobe !== 5'b00001) begin n_err++; $display("FAIL chart_note0: got %b want 00001", lane_strobe); end
    step(1);
    n_cmp++; if (lane_strobe !== 5'b0) begin n_err++; $display("FAIL chart_oneshot: got %b want 00000", lane_strobe); end
    n_cmp++; if (chart_addr !== 8'd1) begin n_err++; $display("FAIL chart_addr1: got %0d want 1", chart_addr); end
    step(6);
    tick();
    step(2);
    n_cmp++; if (lane_strobe !== 5'b00010) begin n_err++; $display("FAIL chart_note1: got %b want 00010", lane_strobe); end
    step(1);
    n_cmp++; if (note_count !== 16'd2) begin n_err++; $display("FAIL chart_count: got %0d want 2", note_count); end
  endtask

  task automatic test_song_end();
    do_reset();
    start_song();
    tick_and_get(s);
    tick_and_get(s);
    tick_and_get(s);
    n_cmp++; if (s !== 5'b10100) begin n_err++; $display("FAIL end_note2: got %b want 10100", s); end
    n_cmp++; if (song_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL end_done: got done=%b busy=%b want 1 0", song_done, busy); end
    n_cmp++; if (note_count !== 16'd3) begin n_err++; $display("FAIL end_count: got %0d want 3", note_count); end
    tick_and_get(s);
    n_cmp++; if (s !== 5'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL end_extra: got strobe=%b ovr=%b want 00000 0", s, overrun); end
    n_cmp++; if (busy !== 1'b0 || song_done !== 1'b0) begin n_err++; $display("FAIL end_idle: got busy=%b done=%b want 0 0", busy, song_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_song();
    beat_tick = 1'b1;
    step(2);
    beat_tick = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
    step(1);
    n_cmp++; if (lane_strobe !== 5'b00001) begin n_err++; $display("FAIL b2b_note: got %b want 00001", lane_strobe); end
    step(3);
    n_cmp++; if (chart_addr !== 8'd1 || note_count !== 16'd1) begin n_err++; $display("FAIL b2b_single: got addr=%0d cnt=%0d want 1 1", chart_addr, note_count); end
    tick_and_get(s);
    n_cmp++; if (s !== 5'b00010 || overrun !== 1'b1) begin n_err++; $display("FAIL b2b_sticky: got strobe=%b ovr=%b want 00010 1", s, overrun); end
    tick_and_get(s);
    step(1);
    start_song();
    n_cmp++; if (overrun !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart: got ovr=%b busy=%b want 0 1", overrun, busy); end
  endtask

  task automatic test_pause();
    do_reset();
    start_song();
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_and_get(s);
      n_cmp++; if (s !== 5'b0) begin n_err++; $display("FAIL pause_tick%0d: got %b want 00000", i, s); end
    end
    n_cmp++; if (chart_addr !== 8'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL pause_hold: got addr=%0d ovr=%b want 0 0", chart_addr, overrun); end
    pause = 1'b0;
    tick_and_get(s);
    n_cmp++; if (s !== 5'b00001) begin n_err++; $display("FAIL pause_release: got %b want 00001", s); end
    tick();
    pause = 1'b1;
    step(2);
    n_cmp++; if (lane_strobe !== 5'b00010) begin n_err++; $display("FAIL pause_inflight: got %b want 00010", lane_strobe); end
    pause = 1'b0;
    step(1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_song();
    tick_and_get(s);
    tick();
    step(1);
    rst = 1'b1;
    step(1);
    n_cmp++; if (lane_strobe !== 5'b0 || busy !== 1'b0 || song_done !== 1'b0) begin n_err++; $display("FAIL midrst_out: got strobe=%b busy=%b done=%b want 00000 0 0", lane_strobe, busy, song_done); end
    n_cmp++; if (chart_addr !== 8'd0 || note_count !== 16'd0 || overrun !== 1'b0) begin n_err++; $display("FAIL midrst_regs: got addr=%0d cnt=%0d ovr=%b want 0 0 0", chart_addr, note_count, overrun); end
    rst = 1'b0;
    step(1);
    n_cmp++; if (lane_strobe !== 5'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle: got strobe=%b busy=%b want 00000 0", lane_strobe, busy); end
  endtask

  task automatic test_mode();
    do_reset();
    mode = 1'b1;
    start_song();
    mode = 1'b0;
`ifdef NOTE_SCHED_RANDOM_EN
    rand_bits = 3'd3;
    tick_and_get(s);
    n_cmp++; if (s !== 5'b00010) begin n_err++; $display("FAIL rand_3: got %b want 00010", s); end
    rand_bits = 3'd6;
    tick_and_get(s);
    n_cmp++; if (s !== 5'b00000) begin n_err++; $display("FAIL rand_6: got %b want 00000", s); end
    n_cmp++; if (note_count !== 16'd1 || chart_addr !== 8'd0) begin n_err++; $display("FAIL rand_count: got cnt=%0d addr=%0d want 1 0", note_count, chart_addr); end
    rand_bits = 3'd0;
    tick_and_get(s);
    tick_and_get(s);
    n_cmp++; if (s !== 5'b10000 || song_done !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL rand_nodone: got strobe=%b done=%b busy=%b want 10000 0 1", s, song_done, busy); end
`else
    rand_bits = 3'd3;
    tick_and_get(s);
    n_cmp++; if (s !== 5'b00001 || chart_addr !== 8'd1) begin n_err++; $display("FAIL mode_ignored: got strobe=%b addr=%0d want 00001 1", s, chart_addr); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 5'b0;
    rom[0] = 5'b00001;
    rom[1] = 5'b00010;
    rom[2] = 5'b10100;
    test_reset();
    test_chart();
    test_song_end();
    test_back_to_back();
    test_pause();
    test_reset_mid();
    test_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
